aes_cipher_iter: RTL and testbench



---
 rtl/aes_cipher_iter.sv | 126 ++++++++++++
 tb/tb_aes_cipher_iter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_cipher_iter.sv
// Iterative AES-128 encryption core: one full cipher round per clock, with round keys
// fetched combinationally from an upstream key schedule via round_idx_o.
module aes_cipher_iter (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_i,
  output logic [3:0]   round_idx_o,
  input  logic [127:0] round_key_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_o,
  output logic         busy
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2} fsm_t;

  fsm_t         fsm, fsm_nxt;
  logic [127:0] state, state_nxt;
  logic [3:0]   rnd, rnd_nxt;

  logic [7:0]   sb [16];
  logic [7:0]   sr [16];
  logic [7:0]   mc [16];
  logic [127:0] sr_flat, mc_flat, round_out;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte k lives at bits [127-8k -: 8]; state[r][c] is byte r+4c.
  always_comb begin
    for (int unsigned k = 0; k < 16; k++) begin
      sb[k] = SBOX[state[127-8*k -: 8]];
    end
    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned c = 0; c < 4; c++) begin
        sr[r + 4*c] = sb[r + 4*((c + r) % 4)];
      end
    end
    for (int unsigned c = 0; c < 4; c++) begin
      mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end
    sr_flat = '0;
    mc_flat = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      sr_flat[127-8*k -: 8] = sr[k];
      mc_flat[127-8*k -: 8] = mc[k];
    end
    round_out = ((rnd == 4'd10) ? sr_flat : mc_flat) ^ round_key_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm   <= IDLE;
      state <= '0;
      rnd   <= '0;
    end else begin
      fsm   <= fsm_nxt;
      state <= state_nxt;
      rnd   <= rnd_nxt;
    end
  end

  always_comb begin
    fsm_nxt     = fsm;
    state_nxt   = state;
    rnd_nxt     = rnd;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    round_idx_o = '0;
    unique case (fsm)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = data_i ^ round_key_i;
          rnd_nxt   = 4'd1;
          fsm_nxt   = ROUND;
        end
      end
      ROUND: begin
        busy        = 1'b1;
        round_idx_o = rnd;
        state_nxt   = round_out;
        rnd_nxt     = rnd + 4'd1;
        if (rnd == 4'd10) fsm_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          fsm_nxt = IDLE;
          rnd_nxt = '0;
        end
      end
      default: fsm_nxt = IDLE;
    endcase
  end

  assign data_o = state;

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Scoreboard bench for aes_cipher_iter: FIPS-197 vectors, backpressure, ignored input,
// mid-round reset and back-to-back issue; the bench supplies round keys from its own expansion.
module tb_aes_cipher_iter;

  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] data_i, round_key_i, data_o;
  logic [3:0]   round_idx_o;

  logic [127:0] rk [2][11];
  int           pend_key = 0;
  int           act_key = 0;
  logic [127:0] pend_exp = '0;
  logic [127:0] exp_q [$];
  int           acc_q [$];
  int           cyc = 0;
  int           checks = 0;
  int           passes = 0;
  logic         prev_ov = 1'b0;

  always #5 clk = ~clk;

  aes_cipher_iter dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .data_i      (data_i),
    .round_idx_o (round_idx_o),
    .round_key_i (round_key_i),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .data_o      (data_o),
    .busy        (busy)
  );

  // Upstream key schedule: the block on data_i uses pend_key, an in-flight block uses act_key.
  always_comb begin
    round_key_i = '0;
    if (round_idx_o <= 4'd10)
      round_key_i = rk[(in_ready === 1'b1) ? pend_key : act_key][round_idx_o];
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual %h required %h", name, act, exp);
  endtask

  task automatic expand(input int ks, input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {SBOX[t[31:24]], SBOX[t[23:16]], SBOX[t[15:8]], SBOX[t[7:0]]} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[ks][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst === 1'b1) begin
      exp_q.delete();
      acc_q.delete();
    end
  end

  // Monitor: records accepted blocks and checks each output presentation.
  always @(negedge clk) begin
    logic [127:0] e;
    int           a;
    if (rst === 1'b0 && in_valid === 1'b1 && in_ready === 1'b1) begin
      exp_q.push_back(pend_exp);
      acc_q.push_back(cyc);
      act_key = pend_key;
    end
    if (out_valid === 1'b1 && prev_ov !== 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_output: actual data_o=%h required no output", data_o);
      end else begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        chk("ciphertext", data_o, e);
        chk("latency", 128'(cyc - a), 128'd11);
      end
    end
    prev_ov = out_valid;
  end

  task automatic send(input logic [127:0] pt, input int key, input logic [127:0] exp);
    int n = 0;
    @(posedge clk); #1;
    data_i = pt; pend_key = key; pend_exp = exp; in_valid = 1'b1;
    do begin @(negedge clk); n++; end while (in_ready !== 1'b1 && n < 50);
    if (n >= 50) begin
      checks++;
      $display("FAIL accept_timeout: actual in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!(in_ready === 1'b1 && exp_q.size() == 0) && n < 100);
    if (n >= 100) begin
      checks++;
      $display("FAIL idle_timeout: actual pending=%0d required 0", exp_q.size());
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 128'(in_ready), 128'd1);
    chk({tag, "_out_valid"}, 128'(out_valid), 128'd0);
    chk({tag, "_busy"}, 128'(busy), 128'd0);
    chk({tag, "_data_o"}, data_o, 128'd0);
    chk({tag, "_round_idx"}, 128'(round_idx_o), 128'd0);
  endtask

  initial begin
    int n, c1, c2;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; data_i = '0;
    expand(0, KEY_C1);
    expand(1, KEY_B);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1 rst = 1'b0;

    // FIPS-197 C.1
    send(PT_C1, 0, CT_C1);
    wait_idle();

    // Appendix B with round index sequence
    @(posedge clk); #1;
    data_i = PT_B; pend_key = 1; pend_exp = CT_B; in_valid = 1'b1;
    @(negedge clk);
    chk("round_idx_0", 128'(round_idx_o), 128'd0);
    @(posedge clk); #1 in_valid = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      chk($sformatf("round_idx_%0d", i), 128'(round_idx_o), 128'(i));
    end
    wait_idle();

    // Output backpressure
    out_ready = 1'b0;
    send(PT_C1, 0, CT_C1);
    n = 0;
    do begin @(negedge clk); n++; end while (out_valid !== 1'b1 && n < 30);
    for (int i = 0; i < 20; i++) begin
      chk("bp_data_o", data_o, CT_C1);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
      chk("bp_out_valid", 128'(out_valid), 128'd1);
      @(negedge clk);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_in_ready", 128'(in_ready), 128'd1);

    // Input ignored while busy
    send(PT_B, 1, CT_B);
    repeat (2) @(posedge clk);
    #1 data_i = PT_C1; in_valid = 1'b1;
    @(negedge clk);
    chk("busy_in_ready", 128'(in_ready), 128'd0);
    @(posedge clk); #1 in_valid = 1'b0;
    wait_idle();
    repeat (15) @(negedge clk);

    // Reset at round 5
    send(PT_C1, 0, CT_C1);
    n = 0;
    while (round_idx_o !== 4'd5 && n < 20) begin @(negedge clk); n++; end
    chk("reach_round5", 128'(round_idx_o), 128'd5);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midreset_in_ready", 128'(in_ready), 128'd1);
    chk("midreset_out_valid", 128'(out_valid), 128'd0);
    chk("midreset_data_o", data_o, 128'd0);
    repeat (15) @(negedge clk);
    send(PT_C1, 0, CT_C1);
    wait_idle();

    // Back-to-back with in_valid and out_ready held high
    @(posedge clk); #1;
    data_i = PT_B; pend_key = 1; pend_exp = CT_B; in_valid = 1'b1;
    c1 = 0; n = 0;
    do begin @(negedge clk); n++; end while (in_ready !== 1'b1 && n < 40);
    c1 = cyc;
    @(posedge clk); #1;
    data_i = PT_C1; pend_key = 0; pend_exp = CT_C1;
    n = 0;
    do begin @(negedge clk); n++; end while (in_ready !== 1'b1 && n < 40);
    c2 = cyc;
    chk("b2b_issue_gap", 128'(c2 - c1), 128'd12);
    @(posedge clk); #1 in_valid = 1'b0;
    wait_idle();
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual time limit reached required finish");
    $fatal(1, "simulation time limit");
  end

endmodule
